// File: rtl/tl_pkg.sv
// Shared types and helpers for the intersection request arbiter.
package tl_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD, EMERG} arb_state_t;

  localparam int N_APPR_DEF = 4;
  localparam int IDX_W      = $clog2(N_APPR_DEF);

  function automatic logic [N_APPR_DEF-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_APPR_DEF-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Button conditioner: 2-FF synchroniser, then a level that flips after DEBOUNCE_CYC differing samples.
// Latency 2 + DEBOUNCE_CYC cycles from a stable input change to level/rise; no backpressure.
module tl_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // This is the DEBOUNCE_CYC-th consecutive differing sample.
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_request_arbiter.sv
// Debounces ped/emergency buttons, latches ped requests and grants them round-robin; TL_ARB_TIMEOUT_EN adds a grant timeout.
// Outputs registered: pending 1 cycle after a debounced edge, preferentials 1 cycle later; lgreen acts as the acknowledge.
module tl_request_arbiter
  import tl_pkg::*;
#(
  parameter int N_APPR       = N_APPR_DEF,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 8,
  parameter int MAX_WAIT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_APPR-1:0] btn_ped,
  input  logic [N_APPR-1:0] btn_emerg,
  input  logic [N_APPR-1:0] lgreen,
  output logic [N_APPR-1:0] preferentials,
  output logic [N_APPR-1:0] force_reds,
  output logic [N_APPR-1:0] pending,
  output logic              emerg_active
);

  localparam int PW = $clog2(N_APPR);
  localparam int HW = $clog2(HOLD_CYC + 1);

  logic [N_APPR-1:0] ped_lvl, ped_rise, emerg_lvl, emerg_rise;

  for (genvar i = 0; i < N_APPR; i++) begin : g_db
    tl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ped (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_ped[i]),
      .level (ped_lvl[i]),
      .rise  (ped_rise[i])
    );
    tl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_emerg (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_emerg[i]),
      .level (emerg_lvl[i]),
      .rise  (emerg_rise[i])
    );
  end

  logic unused_db;
  assign unused_db = ^{ped_lvl, emerg_rise};

  arb_state_t        state, state_n;
  logic [PW-1:0]     rr_ptr, rr_n, sel_n, e_idx;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [N_APPR-1:0] clr, pref_n, fr_n;
  logic              ea_n, found, any_emerg;
`ifdef TL_ARB_TIMEOUT_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0]     wait_cnt, wait_n;
`endif

  // Round-robin search starting just after the last granted approach.
  always_comb begin
    int idx;
    found = 1'b0;
    sel_n = rr_ptr;
    idx   = 0;
    for (int k = 1; k <= N_APPR; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_APPR) idx = idx - N_APPR;
      if (!found && pending[PW'(idx)]) begin
        found = 1'b1;
        sel_n = PW'(idx);
      end
    end
  end

  always_comb begin
    e_idx = '0;
    for (int i = N_APPR - 1; i >= 0; i--) begin
      if (emerg_lvl[i]) e_idx = PW'(i);
    end
  end

  assign any_emerg = |emerg_lvl;

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    hold_n  = hold_cnt;
    clr     = '0;
    pref_n  = '0;
    fr_n    = '0;
    ea_n    = 1'b0;
`ifdef TL_ARB_TIMEOUT_EN
    wait_n  = wait_cnt;
`endif
    // Emergency pre-empts every state; the interrupted request stays pending.
    if (any_emerg) begin
      state_n = EMERG;
      pref_n  = onehot(e_idx);
      fr_n    = ~onehot(e_idx);
      ea_n    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state_n = GRANT;
            rr_n    = sel_n;
            pref_n  = onehot(sel_n);
`ifdef TL_ARB_TIMEOUT_EN
            wait_n  = '0;
`endif
          end
        end
        GRANT: begin
          if (lgreen[rr_ptr]) begin
            state_n = HOLD;
            hold_n  = HW'(HOLD_CYC - 1);
            pref_n  = onehot(rr_ptr);
          end
`ifdef TL_ARB_TIMEOUT_EN
          else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
            state_n = IDLE;
          end else begin
            pref_n = onehot(rr_ptr);
            wait_n = wait_cnt + 1'b1;
          end
`else
          else begin
            pref_n = onehot(rr_ptr);
          end
`endif
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            clr     = onehot(rr_ptr);
            state_n = IDLE;
          end else begin
            hold_n = hold_cnt - 1'b1;
            pref_n = onehot(rr_ptr);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= PW'(N_APPR - 1);
      hold_cnt      <= '0;
      pending       <= '0;
      preferentials <= '0;
      force_reds    <= '0;
      emerg_active  <= 1'b0;
`ifdef TL_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_n;
      hold_cnt      <= hold_n;
      pending       <= (pending | ped_rise) & ~clr;
      preferentials <= pref_n;
      force_reds    <= fr_n;
      emerg_active  <= ea_n;
`ifdef TL_ARB_TIMEOUT_EN
      wait_cnt      <= wait_n;
`endif
    end
  end

endmodule

// File: tb/tb_tl_request_arbiter.sv
// Step-table bench with a scoreboard queue for tl_request_arbiter (DEBOUNCE_CYC=4, HOLD_CYC=3, MAX_WAIT=8).
module tb_tl_request_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] btn_ped, btn_emerg, lgreen;
  logic [3:0] preferentials, force_reds, pending;
  logic       emerg_active;

  tl_request_arbiter #(
    .N_APPR       (4),
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (3),
    .MAX_WAIT     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_ped       (btn_ped),
    .btn_emerg     (btn_emerg),
    .lgreen        (lgreen),
    .preferentials (preferentials),
    .force_reds    (force_reds),
    .pending       (pending),
    .emerg_active  (emerg_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TL_ARB_TIMEOUT_EN
  localparam logic [3:0] T_PREF = 4'b0000;
`else
  localparam logic [3:0] T_PREF = 4'b0001;
`endif

  typedef struct {
    logic [3:0]  ped;
    logic [3:0]  emerg;
    logic [3:0]  lg;
    int          cycles;
    logic [12:0] expv;
    string       name;
  } step_t;

  typedef struct {
    logic [12:0] expv;
    string       name;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic add(input logic [3:0] ped, input logic [3:0] em, input logic [3:0] lg,
                     input int cyc, input logic [3:0] pend, input logic [3:0] pref,
                     input logic [3:0] fr, input logic ea, input string name);
    step_t s;
    s.ped = ped; s.emerg = em; s.lg = lg; s.cycles = cyc;
    s.expv = {pend, pref, fr, ea}; s.name = name;
    steps.push_back(s);
  endtask

  task automatic expect_out(input logic [12:0] v, input string name);
    exp_t x;
    x.expv = v; x.name = name;
    sb.push_back(x);
  endtask

  task automatic compare_out();
    exp_t        x;
    logic [12:0] act;
    x   = sb.pop_front();
    act = {pending, preferentials, force_reds, emerg_active};
    checks++;
    if (act !== x.expv) begin
      errors++;
      $display("FAIL %s: {pend,pref,fr,ea} got %b_%b_%b_%b want %b_%b_%b_%b", x.name,
               act[12:9], act[8:5], act[4:1], act[0],
               x.expv[12:9], x.expv[8:5], x.expv[4:1], x.expv[0]);
    end
  endtask

  initial begin
    rst = 1'b1; btn_ped = '0; btn_emerg = '0; lgreen = '0;
    repeat (2) @(negedge clk);
    expect_out('0, "rst_asserted");
    compare_out();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_out('0, "rst_idle");
    compare_out();

    // Two-sample glitch never reaches the debounce threshold.
    btn_ped = 4'b0001;
    repeat (2) @(negedge clk);
    btn_ped = 4'b0000;
    expect_out('0, "glitch");
    repeat (10) @(negedge clk);
    compare_out();

    //   ped      emerg    lgreen   cyc pend     pref     fr       ea
    add(4'b0001, 4'b0000, 4'b0000, 7, 4'b0001, 4'b0000, 4'b0000, 0, "t1_pend");
    add(4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000, 0, "t1_pref");
    add(4'b0000, 4'b0000, 4'b0001, 3, 4'b0001, 4'b0001, 4'b0000, 0, "t1_hold");
    add(4'b0000, 4'b0000, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 0, "t1_done");
    add(4'b0010, 4'b0000, 4'b0000, 8, 4'b0010, 4'b0010, 4'b0000, 0, "t2_g1a");
    add(4'b0000, 4'b0000, 4'b0010, 3, 4'b0010, 4'b0010, 4'b0000, 0, "t2_h1");
    add(4'b0000, 4'b0000, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0000, 0, "t2_s1");
    add(4'b0000, 4'b0000, 4'b0000, 8, 4'b0000, 4'b0000, 4'b0000, 0, "t2_idle");
    add(4'b0110, 4'b0000, 4'b0000, 7, 4'b0110, 4'b0000, 4'b0000, 0, "t2_pend");
    add(4'b0110, 4'b0000, 4'b0000, 1, 4'b0110, 4'b0100, 4'b0000, 0, "t2_g2_first");
    add(4'b0000, 4'b0000, 4'b0100, 3, 4'b0110, 4'b0100, 4'b0000, 0, "t2_h2");
    add(4'b0000, 4'b0000, 4'b0100, 1, 4'b0010, 4'b0000, 4'b0000, 0, "t2_s2");
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0010, 4'b0000, 0, "t2_g1_next");
    add(4'b0000, 4'b0000, 4'b0010, 4, 4'b0000, 4'b0000, 4'b0000, 0, "t2_s1b");
    add(4'b0001, 4'b0000, 4'b0000, 8, 4'b0001, 4'b0001, 4'b0000, 0, "t3_g0");
    add(4'b0000, 4'b1000, 4'b0000, 5, 4'b0001, 4'b0001, 4'b0000, 0, "t3_grant");
    add(4'b0000, 4'b1000, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 0, "t3_hold");
    add(4'b0000, 4'b1000, 4'b0001, 1, 4'b0001, 4'b1000, 4'b0111, 1, "t3_preempt");
    add(4'b0000, 4'b0000, 4'b0000, 6, 4'b0001, 4'b1000, 4'b0111, 1, "t3_emerg_held");
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 0, "t3_release");
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000, 0, "t3_regrant0");
    add(4'b0000, 4'b0000, 4'b0001, 4, 4'b0000, 4'b0000, 4'b0000, 0, "t3_serve");
    add(4'b0000, 4'b0110, 4'b0000, 7, 4'b0000, 4'b0010, 4'b1101, 1, "t4_lowest");
    add(4'b0000, 4'b0100, 4'b0000, 6, 4'b0000, 4'b0010, 4'b1101, 1, "t4_keep");
    add(4'b0000, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0100, 4'b1011, 1, "t4_reeval");
    add(4'b0000, 4'b0000, 4'b0000, 7, 4'b0000, 4'b0000, 4'b0000, 0, "t4_clear");
    add(4'b1001, 4'b0000, 4'b0000, 8, 4'b1001, 4'b1000, 4'b0000, 0, "t5_g3");
    add(4'b0000, 4'b0000, 4'b1000, 4, 4'b0001, 4'b0000, 4'b0000, 0, "t5_s3");
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000, 0, "t5_wrap0");
    add(4'b0000, 4'b0000, 4'b0000, 7, 4'b0001, 4'b0001, 4'b0000, 0, "t5_wait");
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, T_PREF,  4'b0000, 0, "t5_timeout");
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000, 0, "t5_after");
    add(4'b0000, 4'b0000, 4'b0000, 20, 4'b0001, 4'b0001, 4'b0000, 0, "t5_long");

    foreach (steps[i]) begin
      btn_ped   = steps[i].ped;
      btn_emerg = steps[i].emerg;
      lgreen    = steps[i].lg;
      expect_out(steps[i].expv, steps[i].name);
      repeat (steps[i].cycles) @(negedge clk);
      compare_out();
    end

    // Asynchronous reset in the middle of a grant, well before the next clock edge.
    #2 rst = 1'b1;
    expect_out('0, "t6_rst_async");
    #1 compare_out();
    @(negedge clk);
    rst = 1'b0;
    expect_out('0, "t6_pending_lost");
    repeat (4) @(negedge clk);
    compare_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
